// File: rtl/enc_pkg.sv
// Shared opcode, sub-command codes, FSM encoding and width helpers for the ENC issue controller.
package enc_pkg;

   localparam logic [6:0] OP_ENC = 7'b0001011;

   localparam logic [2:0] F3_KEY_WR    = 3'b000;
   localparam logic [2:0] F3_DATA_WR   = 3'b001;
   localparam logic [2:0] F3_START_ENC = 3'b010;
   localparam logic [2:0] F3_START_DEC = 3'b011;
   localparam logic [2:0] F3_FENCE     = 3'b100;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StBusy = 1'b1
   } enc_state_e;

   // Never returns 0 so that derived vectors always have at least one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned idx_width(input int unsigned k, input int unsigned d);
      return clog2_min1((k > d) ? k : d);
   endfunction

endpackage

// File: rtl/enc_timeout_cnt.sv
// Clear/enable up-counter for the BUSY watchdog; tc flags the terminal count.
module enc_timeout_cnt
   import enc_pkg::*;
#(
   parameter int unsigned TERMINAL = 1023
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned CNT_W = clog2_min1(TERMINAL + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == CNT_W'(TERMINAL));

endmodule

// File: rtl/enc_issue_ctrl.sv
// Issue controller for the encryption accelerator: word loads, start/abort sequencing,
// decode stall while the accelerator is busy, watchdog timeout with sticky error.
module enc_issue_ctrl
   import enc_pkg::*;
#(
   parameter  int unsigned KEY_WORDS      = 4,
   parameter  int unsigned DATA_WORDS     = 4,
   parameter  int unsigned TIMEOUT_CYCLES = 1024,
   localparam int unsigned IDX_W          = idx_width(KEY_WORDS, DATA_WORDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dec_valid,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic [31:0]      rs1_data,
   output logic             stall,
   output logic             illegal_insn,
   output logic             acc_wr_en,
   output logic             acc_wr_sel,
   output logic [IDX_W-1:0] acc_wr_idx,
   output logic [31:0]      acc_wr_data,
   output logic             acc_start,
   output logic             acc_mode,
   output logic             acc_abort,
   input  logic             acc_done,
   output logic             enc_busy,
   output logic             enc_err,
   input  logic             err_clr
);

   enc_state_e state_q, state_d;

   logic             illegal_q, illegal_d;
   logic             wr_en_q, wr_en_d;
   logic             wr_sel_q, wr_sel_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic [31:0]      wr_data_q, wr_data_d;
   logic             start_q, start_d;
   logic             mode_q, mode_d;
   logic             abort_q, abort_d;
   logic             err_q, err_d;

   logic        is_enc;
   logic        legal;
   logic        accept;
   logic        is_start;
   logic        f7_hi_ok;
   logic [31:0] idx_ext;
   logic        timeout_tc;

   // Instruction legality depends only on the instruction, never on FSM state.
   always_comb begin
      is_enc   = dec_valid && (op == OP_ENC);
      idx_ext  = 32'(funct7[IDX_W-1:0]);
      f7_hi_ok = ((funct7 >> IDX_W) == 7'd0);
      case (funct3)
         F3_KEY_WR:                          legal = f7_hi_ok && (idx_ext < KEY_WORDS);
         F3_DATA_WR:                         legal = f7_hi_ok && (idx_ext < DATA_WORDS);
         F3_START_ENC, F3_START_DEC, F3_FENCE: legal = 1'b1;
         default:                            legal = 1'b0;
      endcase
      stall    = is_enc && legal && (state_q != StIdle);
      accept   = is_enc && legal && (state_q == StIdle);
      is_start = accept && ((funct3 == F3_START_ENC) || (funct3 == F3_START_DEC));
   end

   enc_timeout_cnt #(
      .TERMINAL (TIMEOUT_CYCLES - 1)
   ) u_timeout_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (is_start),
      .en    (state_q == StBusy),
      .tc    (timeout_tc)
   );

   always_comb begin
      state_d   = state_q;
      illegal_d = is_enc && !legal;
      wr_en_d   = 1'b0;
      wr_sel_d  = 1'b0;
      wr_idx_d  = '0;
      wr_data_d = '0;
      start_d   = 1'b0;
      mode_d    = 1'b0;
      abort_d   = 1'b0;
      err_d     = err_q;
      if (err_clr) begin
         err_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (accept) begin
               case (funct3)
                  F3_KEY_WR, F3_DATA_WR: begin
                     wr_en_d   = 1'b1;
                     wr_sel_d  = (funct3 == F3_DATA_WR);
                     wr_idx_d  = funct7[IDX_W-1:0];
                     wr_data_d = rs1_data;
                  end
                  F3_START_ENC, F3_START_DEC: begin
                     start_d = 1'b1;
                     mode_d  = (funct3 == F3_START_DEC);
                     state_d = StBusy;
                  end
                  default: ;
               endcase
            end
         end
         StBusy: begin
            // A completion in the terminal cycle beats the watchdog.
            if (acc_done) begin
               state_d = StIdle;
            end else if (timeout_tc) begin
               abort_d = 1'b1;
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         illegal_q <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_sel_q  <= 1'b0;
         wr_idx_q  <= '0;
         wr_data_q <= '0;
         start_q   <= 1'b0;
         mode_q    <= 1'b0;
         abort_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         wr_en_q   <= wr_en_d;
         wr_sel_q  <= wr_sel_d;
         wr_idx_q  <= wr_idx_d;
         wr_data_q <= wr_data_d;
         start_q   <= start_d;
         mode_q    <= mode_d;
         abort_q   <= abort_d;
         err_q     <= err_d;
      end
   end

   assign illegal_insn = illegal_q;
   assign acc_wr_en    = wr_en_q;
   assign acc_wr_sel   = wr_sel_q;
   assign acc_wr_idx   = wr_idx_q;
   assign acc_wr_data  = wr_data_q;
   assign acc_start    = start_q;
   assign acc_mode     = mode_q;
   assign acc_abort    = abort_q;
   assign enc_busy     = (state_q == StBusy);
   assign enc_err      = err_q;

endmodule

// File: tb/tb_enc_issue_ctrl.sv
// Scoreboard bench for enc_issue_ctrl: directed stimulus queues expected strobes, a monitor checks.
module tb_enc_issue_ctrl;

   localparam logic [6:0] ENC_OP = 7'b0001011;
   localparam int K_WR    = 0;
   localparam int K_START = 1;
   localparam int K_ABORT = 2;
   localparam int K_ILL   = 3;

   logic        clk = 1'b0;
   logic        reset, dec_valid, err_clr, acc_done;
   logic [6:0]  op, funct7;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic        stall, illegal_insn, acc_wr_en, acc_wr_sel, acc_start, acc_mode, acc_abort;
   logic        enc_busy, enc_err;
   logic [1:0]  acc_wr_idx;
   logic [31:0] acc_wr_data;

   typedef struct {
      int          kind;
      logic        sel;
      logic [1:0]  idx;
      logic [31:0] data;
      logic        mode;
      int          due;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   enc_issue_ctrl #(
      .KEY_WORDS      (4),
      .DATA_WORDS     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .dec_valid    (dec_valid),
      .op           (op),
      .funct3       (funct3),
      .funct7       (funct7),
      .rs1_data     (rs1_data),
      .stall        (stall),
      .illegal_insn (illegal_insn),
      .acc_wr_en    (acc_wr_en),
      .acc_wr_sel   (acc_wr_sel),
      .acc_wr_idx   (acc_wr_idx),
      .acc_wr_data  (acc_wr_data),
      .acc_start    (acc_start),
      .acc_mode     (acc_mode),
      .acc_abort    (acc_abort),
      .acc_done     (acc_done),
      .enc_busy     (enc_busy),
      .enc_err      (enc_err),
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   task automatic push(input int kind, input logic sel, input logic [1:0] idx,
                       input logic [31:0] data, input logic mode, input int dly);
      exp_t e;
      e.kind = kind; e.sel = sel; e.idx = idx; e.data = data; e.mode = mode;
      e.due  = cyc + dly;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] d);
      dec_valid = 1'b1; op = ENC_OP; funct3 = f3; funct7 = f7; rs1_data = d;
   endtask

   task automatic idle_in();
      dec_valid = 1'b0; op = 7'd0; funct3 = 3'd0; funct7 = 7'd0; rs1_data = 32'd0;
   endtask

   // Monitor: every strobe must match the oldest expectation, in kind, fields and cycle.
   always @(negedge clk) begin
      exp_t e;
      int   ak;
      logic ok;
      if (!reset && (acc_wr_en || acc_start || acc_abort || illegal_insn)) begin
         checks++;
         ak = acc_wr_en ? K_WR : acc_start ? K_START : acc_abort ? K_ABORT : K_ILL;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe cyc=%0d got wr=%b start=%b abort=%b ill=%b required none",
                     cyc, acc_wr_en, acc_start, acc_abort, illegal_insn);
         end else begin
            e  = q.pop_front();
            ok = ($countones({acc_wr_en, acc_start, acc_abort, illegal_insn}) == 1) &&
                 (ak == e.kind) && (cyc == e.due);
            if (e.kind == K_WR)
               ok = ok && (acc_wr_sel == e.sel) && (acc_wr_idx == e.idx) && (acc_wr_data == e.data);
            if (e.kind == K_START) ok = ok && (acc_mode == e.mode);
            if (!ok) begin
               failures++;
               $display("FAIL strobe cyc=%0d got kind=%0d sel=%b idx=%0d data=%0h mode=%b required kind=%0d sel=%b idx=%0d data=%0h mode=%b due=%0d",
                        cyc, ak, acc_wr_sel, acc_wr_idx, acc_wr_data, acc_mode,
                        e.kind, e.sel, e.idx, e.data, e.mode, e.due);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; err_clr = 1'b0; acc_done = 1'b0;
      idle_in();
      step(); step();
      check("rst_busy", enc_busy, 0);
      check("rst_err", enc_err, 0);
      check("rst_strobes", {acc_wr_en, acc_start, acc_abort, illegal_insn}, 0);
      check("rst_stall", stall, 0);
      reset = 1'b0;
      step();

      // Back-to-back key writes.
      for (int i = 0; i < 4; i++) begin
         drive(3'b000, 7'(i), 32'hA0 + 32'(i));
         push(K_WR, 1'b0, 2'(i), 32'hA0 + 32'(i), 1'b0, 1);
         #1 check("kw_stall", stall, 0);
         step();
      end
      // Non-ENC opcode has no effect.
      drive(3'b000, 7'd1, 32'hDEAD);
      op = 7'b0110011;
      #1 check("nonenc_stall", stall, 0);
      step();
      idle_in();

      // START_ENC with a DATA_WR held in decode during BUSY.
      drive(3'b010, 7'd0, 32'd0);
      push(K_START, 1'b0, 2'd0, 32'd0, 1'b0, 1);
      step();
      check("se_busy", enc_busy, 1);
      drive(3'b001, 7'd2, 32'h55);
      #1 check("se_stall", stall, 1);
      for (int i = 0; i < 11; i++) begin
         step();
         check("se_stall_hold", stall, 1);
      end
      acc_done = 1'b1;
      step();
      acc_done = 1'b0;
      check("se_idle_stall", stall, 0);
      check("se_idle_busy", enc_busy, 0);
      push(K_WR, 1'b1, 2'd2, 32'h55, 1'b0, 1);
      step();
      idle_in();

      // FENCE while idle and acc_done while idle have no effect.
      drive(3'b100, 7'd0, 32'd0);
      #1 check("fence_idle_stall", stall, 0);
      step();
      idle_in();
      acc_done = 1'b1;
      step();
      acc_done = 1'b0;
      check("done_idle_busy", enc_busy, 0);

      // Timeout on START_DEC.
      drive(3'b011, 7'd0, 32'd0);
      push(K_START, 1'b0, 2'd0, 32'd0, 1'b1, 1);
      push(K_ABORT, 1'b0, 2'd0, 32'd0, 1'b0, 17);
      step();
      idle_in();
      repeat (15) step();
      check("to_busy_c15", enc_busy, 1);
      check("to_noabort_c15", acc_abort, 0);
      step();
      check("to_abort", acc_abort, 1);
      check("to_idle", enc_busy, 0);
      check("to_err", enc_err, 1);
      step();
      check("to_err_sticky", enc_err, 1);
      check("to_abort_pulse", acc_abort, 0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("to_err_clr", enc_err, 0);
      drive(3'b010, 7'd0, 32'd0);
      push(K_START, 1'b0, 2'd0, 32'd0, 1'b0, 1);
      step();
      idle_in();
      check("to_restart_busy", enc_busy, 1);
      acc_done = 1'b1;
      step();
      acc_done = 1'b0;
      check("to_restart_idle", enc_busy, 0);

      // Illegal instructions.
      drive(3'b111, 7'd0, 32'd0);
      push(K_ILL, 1'b0, 2'd0, 32'd0, 1'b0, 1);
      #1 check("ill_f3_stall", stall, 0);
      step();
      drive(3'b000, 7'd4, 32'h77);
      push(K_ILL, 1'b0, 2'd0, 32'd0, 1'b0, 1);
      #1 check("ill_idx_stall", stall, 0);
      step();
      drive(3'b001, 7'h40, 32'h78);
      push(K_ILL, 1'b0, 2'd0, 32'd0, 1'b0, 1);
      step();
      drive(3'b010, 7'd0, 32'd0);
      push(K_START, 1'b0, 2'd0, 32'd0, 1'b0, 1);
      step();
      drive(3'b101, 7'd0, 32'd0);
      push(K_ILL, 1'b0, 2'd0, 32'd0, 1'b0, 1);
      #1 check("ill_busy_stall", stall, 0);
      step();
      drive(3'b100, 7'd0, 32'd0);
      #1 check("fence_busy_stall", stall, 1);
      step();
      idle_in();
      acc_done = 1'b1;
      step();
      acc_done = 1'b0;

      // acc_done coincident with terminal count.
      drive(3'b010, 7'd0, 32'd0);
      push(K_START, 1'b0, 2'd0, 32'd0, 1'b0, 1);
      step();
      idle_in();
      repeat (15) step();
      acc_done = 1'b1;
      step();
      acc_done = 1'b0;
      check("tie_abort", acc_abort, 0);
      check("tie_idle", enc_busy, 0);
      check("tie_err", enc_err, 0);

      // Error set beats err_clr, then reset mid-BUSY.
      drive(3'b011, 7'd0, 32'd0);
      push(K_START, 1'b0, 2'd0, 32'd0, 1'b1, 1);
      push(K_ABORT, 1'b0, 2'd0, 32'd0, 1'b0, 17);
      step();
      idle_in();
      repeat (15) step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("setclr_err", enc_err, 1);
      drive(3'b010, 7'd0, 32'd0);
      push(K_START, 1'b0, 2'd0, 32'd0, 1'b0, 1);
      step();
      idle_in();
      repeat (3) step();
      check("mid_busy", enc_busy, 1);
      reset = 1'b1;
      step();
      check("rstb_busy", enc_busy, 0);
      check("rstb_err", enc_err, 0);
      check("rstb_strobes", {acc_wr_en, acc_start, acc_abort, illegal_insn}, 0);
      reset = 1'b0;
      step();
      check("rstb_after", enc_busy, 0);

      repeat (3) step();
      check("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
